// File: rtl/i2s_tdm_pkg.sv
// Shared types and helpers for the I2S/TDM transmit VIP.
package i2s_tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_e;

  // Value of cfg_dsp_mode_i selecting which bclk edge shifts data.
  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_tdm_tx_fifo.sv
// Synchronous frame FIFO with show-ahead read data.
module i2s_tdm_tx_fifo
  import i2s_tdm_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = cnt_width(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i2s_tdm_tx_device.sv
// TDM serial transmitter slaved to an external bit clock and frame sync.
module i2s_tdm_tx_device
  import i2s_tdm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SLOT_WIDTH = 32,
  parameter int NUM_SLOTS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cfg_en_i,
  input  logic                            cfg_lsb_first_i,
  input  logic                            cfg_dsp_mode_i,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] data_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic                            bclk_i,
  input  logic                            ws_i,
  output logic                            sd_o,
  output logic                            ws_o,
  output logic                            underrun_o,
  output logic                            resync_o
);

  localparam int FRAME_W = NUM_SLOTS * DATA_WIDTH;
  localparam int BIT_W   = cnt_width(SLOT_WIDTH);
  localparam int SLOT_W  = cnt_width(NUM_SLOTS);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = 1;
  localparam logic [SLOT_W-1:0] SLOT_ONE  = 1;

  logic bclk_s1, bclk_s2, bclk_s3;
  logic ws_s1, ws_s2, ws_d;
  logic active_edge;
  logic frame_start;
  logic last_bit;

  tx_state_e         state_q;
  logic [BIT_W-1:0]  bit_q;
  logic [SLOT_W-1:0] slot_q;
  logic [FRAME_W-1:0] frame_q;

  logic [FRAME_W-1:0]    fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FRAME_W-1:0]    frame_sh;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] word_sh;
  logic                  bit_val;

  assign ready_o     = !fifo_full;
  assign active_edge = (cfg_dsp_mode_i == EDGE_RISE) ? (bclk_s2 && !bclk_s3)
                                                     : (!bclk_s2 && bclk_s3);
  assign last_bit    = (bit_q == BIT_LAST) && (slot_q == SLOT_LAST);
  assign frame_start = cfg_en_i && active_edge && ws_s2;

  i2s_tdm_tx_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (valid_i && ready_o),
    .pop   (frame_start),
    .wdata (data_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Bring bclk and ws into the system clock domain; ws_o is delayed to line up with sd_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_s3 <= 1'b0;
      ws_s1   <= 1'b0;
      ws_s2   <= 1'b0;
      ws_d    <= 1'b0;
      ws_o    <= 1'b0;
    end else begin
      bclk_s1 <= bclk_i;
      bclk_s2 <= bclk_s1;
      bclk_s3 <= bclk_s2;
      ws_s1   <= ws_i;
      ws_s2   <= ws_s1;
      ws_d    <= ws_s2;
      ws_o    <= ws_d;
    end
  end

  // Select the bit for the current slot/bit position; padding bits past DATA_WIDTH are zero.
  always_comb begin
    frame_sh = frame_q >> (int'(slot_q) * DATA_WIDTH);
    cur_word = frame_sh[DATA_WIDTH-1:0];
    word_sh  = '0;
    bit_val  = 1'b0;
    if (int'(bit_q) < DATA_WIDTH) begin
      if (cfg_lsb_first_i) word_sh = cur_word >> bit_q;
      else                 word_sh = cur_word >> (DATA_WIDTH - 1 - int'(bit_q));
      bit_val = word_sh[0];
    end
  end

  // Frame sequencer: a ws on the active edge (re)starts a frame, otherwise bit/slot advance.
  // A ws landing on the final bit is a normal back-to-back frame, not a resync.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_q      <= '0;
      slot_q     <= '0;
      frame_q    <= '0;
      sd_o       <= 1'b0;
      underrun_o <= 1'b0;
      resync_o   <= 1'b0;
    end else begin
      sd_o       <= (state_q == RUN && cfg_en_i) ? bit_val : 1'b0;
      underrun_o <= 1'b0;
      resync_o   <= 1'b0;
      if (!cfg_en_i) begin
        state_q <= IDLE;
        bit_q   <= '0;
        slot_q  <= '0;
      end else if (frame_start) begin
        frame_q    <= fifo_empty ? '0 : fifo_rdata;
        underrun_o <= fifo_empty;
        resync_o   <= (state_q == RUN) && !last_bit;
        state_q    <= RUN;
        bit_q      <= '0;
        slot_q     <= '0;
      end else if (active_edge && state_q == RUN) begin
        if (bit_q == BIT_LAST) begin
          bit_q <= '0;
          if (slot_q == SLOT_LAST) begin
            state_q <= IDLE;
            slot_q  <= '0;
          end else begin
            slot_q <= slot_q + SLOT_ONE;
          end
        end else begin
          bit_q <= bit_q + BIT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx_device.sv
// Self-checking bench for the I2S/TDM transmitter: a default 2x32 instance and a 4-slot 24-in-32 instance.
module tb_i2s_tdm_tx_device;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en1;
  logic        lsb, dsp;
  logic [63:0] data0;
  logic [95:0] data1;
  logic        valid0, valid1;
  logic        ready0, ready1;
  logic        bclk, ws;
  logic        sd0, sd1, wso0, wso1;
  logic        und0, und1, rsy0, rsy1;

  int checks = 0;
  int errors = 0;
  int und_cnt [2] = '{default: 0};
  int rsy_cnt [2] = '{default: 0};

  logic [127:0] q0 [$];
  logic [127:0] q1 [$];
  logic         prev_exp [2];
  logic         prev_ws;

  i2s_tdm_tx_device dut0 (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_en_i        (en0),
    .cfg_lsb_first_i (lsb),
    .cfg_dsp_mode_i  (dsp),
    .data_i          (data0),
    .valid_i         (valid0),
    .ready_o         (ready0),
    .bclk_i          (bclk),
    .ws_i            (ws),
    .sd_o            (sd0),
    .ws_o            (wso0),
    .underrun_o      (und0),
    .resync_o        (rsy0)
  );

  i2s_tdm_tx_device #(
    .DATA_WIDTH (24),
    .SLOT_WIDTH (32),
    .NUM_SLOTS  (4),
    .FIFO_DEPTH (4)
  ) dut1 (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_en_i        (en1),
    .cfg_lsb_first_i (lsb),
    .cfg_dsp_mode_i  (dsp),
    .data_i          (data1),
    .valid_i         (valid1),
    .ready_o         (ready1),
    .bclk_i          (bclk),
    .ws_i            (ws),
    .sd_o            (sd1),
    .ws_o            (wso1),
    .underrun_o      (und1),
    .resync_o        (rsy1)
  );

  // System clock, 10 ns period.
  always #5 clk = ~clk;

  // Count single-cycle status pulses, sampled away from the active clock edge.
  always @(negedge clk) begin
    if (und0) und_cnt[0]++;
    if (und1) und_cnt[1]++;
    if (rsy0) rsy_cnt[0]++;
    if (rsy1) rsy_cnt[1]++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected serial bit at (slot, b) of a frame, straight from the word/bit-order rules.
  function automatic logic exp_bit(input logic [127:0] frame, input int dw, input int slot,
                                   input int b, input logic lsb_first);
    logic [127:0] word;
    logic [127:0] sh;
    if (b >= dw) return 1'b0;
    word = (frame >> (slot * dw)) & ((128'd1 << dw) - 128'd1);
    sh   = lsb_first ? (word >> b) : (word >> (dw - 1 - b));
    return sh[0];
  endfunction

  // Offer one frame; the model accepts it only if it believes the FIFO has room.
  task automatic applyStimulus(input int dut, input logic [127:0] f);
    logic exp_ready;
    @(negedge clk);
    if (dut == 0) begin
      exp_ready = (q0.size() < 4);
      checkOutput("ready0", 64'(ready0), 64'(exp_ready));
      data0  = f[63:0];
      valid0 = 1'b1;
      if (exp_ready) q0.push_back(f);
    end else begin
      exp_ready = (q1.size() < 4);
      checkOutput("ready1", 64'(ready1), 64'(exp_ready));
      data1  = f[95:0];
      valid1 = 1'b1;
      if (exp_ready) q1.push_back(f);
    end
    @(negedge clk);
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  // One bclk period (8 clk): inactive edge with ws update, then active edge.
  // Outputs are sampled 3 and 4 clk after each pin change to pin down the latency.
  task automatic bclk_period(input logic ws_val, input int dut, output logic sd_early,
                             output logic sd_late, output logic ws_early, output logic ws_late);
    bclk = dsp ? 1'b0 : 1'b1;
    ws   = ws_val;
    repeat (3) @(negedge clk);
    ws_early = (dut == 0) ? wso0 : wso1;
    @(negedge clk);
    ws_late = (dut == 0) ? wso0 : wso1;
    bclk = dsp ? 1'b1 : 1'b0;
    repeat (3) @(negedge clk);
    sd_early = (dut == 0) ? sd0 : sd1;
    @(negedge clk);
    sd_late = (dut == 0) ? sd0 : sd1;
  endtask

  task automatic idle_period(input int dut);
    logic sde, sdl, wse, wsl;
    bclk_period(1'b0, dut, sde, sdl, wse, wsl);
    checkOutput("idle_ws_hold", 64'(wse), 64'(prev_ws));
    checkOutput("idle_ws", 64'(wsl), 64'd0);
    checkOutput("idle_sd_hold", 64'(sde), 64'(prev_exp[dut]));
    checkOutput("idle_sd", 64'(sdl), 64'd0);
    prev_ws       = 1'b0;
    prev_exp[dut] = 1'b0;
  endtask

  // Pulse ws and check nbits serial bits of the frame the model expects to be popped.
  task automatic run_frame(input int dut, input int nbits, input logic exp_resync);
    logic [127:0] f;
    logic         exp_under;
    logic         sde, sdl, wse, wsl, e;
    int           und_before, rsy_before, dw;
    dw         = (dut == 0) ? 32 : 24;
    und_before = und_cnt[dut];
    rsy_before = rsy_cnt[dut];
    exp_under  = 1'b0;
    f          = '0;
    if (dut == 0) begin
      if (q0.size() == 0) exp_under = 1'b1;
      else f = q0.pop_front();
    end else begin
      if (q1.size() == 0) exp_under = 1'b1;
      else f = q1.pop_front();
    end
    for (int p = 0; p < nbits; p++) begin
      bclk_period(p == 0, dut, sde, sdl, wse, wsl);
      e = exp_bit(f, dw, p / 32, p % 32, lsb);
      checkOutput($sformatf("ws_o_hold%0d", p), 64'(wse), 64'(prev_ws));
      checkOutput($sformatf("ws_o%0d", p), 64'(wsl), 64'(p == 0));
      checkOutput($sformatf("sd_hold%0d", p), 64'(sde), 64'(prev_exp[dut]));
      checkOutput($sformatf("sd_bit%0d", p), 64'(sdl), 64'(e));
      prev_ws       = (p == 0);
      prev_exp[dut] = e;
    end
    checkOutput("underrun_pulses", 64'(und_cnt[dut] - und_before), 64'(exp_under));
    checkOutput("resync_pulses", 64'(rsy_cnt[dut] - rsy_before), 64'(exp_resync));
  endtask

  initial begin
    logic sde, sdl, wse, wsl;
    int   und_before;
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; lsb = 1'b0; dsp = 1'b0;
    data0 = '0; data1 = '0; valid0 = 1'b0; valid1 = 1'b0;
    bclk = 1'b0; ws = 1'b0;
    prev_exp = '{1'b0, 1'b0};
    prev_ws  = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_sd0", 64'(sd0), 64'd0);
    checkOutput("rst_sd1", 64'(sd1), 64'd0);
    checkOutput("rst_ws_o", 64'(wso0), 64'd0);
    checkOutput("rst_underrun", 64'(und0), 64'd0);
    checkOutput("rst_resync", 64'(rsy0), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rel_ready0", 64'(ready0), 64'd1);
    checkOutput("rel_ready1", 64'(ready1), 64'd1);

    $display("[TB] MSB first, falling edge");
    en0 = 1'b1;
    applyStimulus(0, {64'd0, 32'hA5A5_0001, 32'h8000_00FF});
    idle_period(0);
    run_frame(0, 64, 1'b0);
    idle_period(0);

    $display("[TB] LSB first, rising edge");
    lsb = 1'b1;
    dsp = 1'b1;
    applyStimulus(0, {64'd0, 32'hA5A5_0001, 32'h8000_00FF});
    idle_period(0);
    run_frame(0, 64, 1'b0);
    idle_period(0);

    $display("[TB] 4 slots of 24 bits in 32-bit slots");
    en0 = 1'b0;
    en1 = 1'b1;
    lsb = 1'b0;
    applyStimulus(1, {32'd0, {4{24'hFF_FFFF}}});
    run_frame(1, 128, 1'b0);
    idle_period(1);
    idle_period(1);
    en1 = 1'b0;
    en0 = 1'b1;

    $display("[TB] random frames and modes");
    for (int i = 0; i < 4; i++) begin
      lsb = 1'($urandom_range(0, 1));
      dsp = 1'($urandom_range(0, 1));
      applyStimulus(0, {64'd0, $urandom, $urandom});
      idle_period(0);
      run_frame(0, 64, 1'b0);
      idle_period(0);
    end

    $display("[TB] underrun on empty FIFO");
    run_frame(0, 64, 1'b0);
    idle_period(0);

    $display("[TB] resync at bit 10");
    applyStimulus(0, {64'd0, $urandom, $urandom});
    applyStimulus(0, {64'd0, $urandom, $urandom});
    run_frame(0, 10, 1'b0);
    run_frame(0, 64, 1'b1);
    idle_period(0);

    $display("[TB] enable drop keeps FIFO");
    applyStimulus(0, {64'd0, $urandom, 32'hFFFF_0000 | $urandom});
    applyStimulus(0, {64'd0, $urandom, $urandom});
    run_frame(0, 5, 1'b0);
    en0 = 1'b0;
    @(negedge clk);
    checkOutput("en_off_sd", 64'(sd0), 64'd0);
    prev_exp[0] = 1'b0;
    und_before = und_cnt[0];
    bclk_period(1'b1, 0, sde, sdl, wse, wsl);
    checkOutput("en_off_ws_sd", 64'(sdl), 64'd0);
    checkOutput("en_off_no_underrun", 64'(und_cnt[0] - und_before), 64'd0);
    prev_ws = 1'b1;
    en0 = 1'b1;
    idle_period(0);
    run_frame(0, 64, 1'b0);
    idle_period(0);

    $display("[TB] full FIFO then reset mid-frame");
    lsb = 1'b0;
    dsp = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(0, {64'd0, $urandom, 32'hFFC0_0000 | $urandom});
    idle_period(0);
    run_frame(0, 10, 1'b0);
    applyStimulus(0, {64'd0, $urandom, $urandom});
    applyStimulus(0, {64'd0, $urandom, $urandom});
    checkOutput("full_sd_before_rst", 64'(sd0), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_sd", 64'(sd0), 64'd0);
    checkOutput("rst_mid_underrun", 64'(und0), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    prev_exp = '{1'b0, 1'b0};
    prev_ws  = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_ready", 64'(ready0), 64'd1);
    run_frame(0, 64, 1'b0);
    idle_period(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
